kf_frame_sequencer: RTL

//  Hardware initiator for top_kf: accepts one measurement/input sample per frame on a valid/ready stream,

---
 rtl/kf_frame_sequencer_if.sv | 58 +++++
 rtl/kf_frame_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/kf_frame_sequencer_if.sv
//============================================================================
// Module   : kf_frame_sequencer_if
// Purpose  : Bundles the sample input stream, the top_kf operand/launch bus
//            and the estimate output stream of kf_frame_sequencer.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface kf_frame_sequencer_if #(
  parameter int N = 20
);
  // Sample input stream
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_u00;
  logic [N-1:0] s_z00;
  logic [N-1:0] s_z10;
  // top_kf launch / completion and operands
  logic         kf_start;
  logic         kf_done;
  logic [N-1:0] kf_x00_post;
  logic [N-1:0] kf_x10_post;
  logic [N-1:0] kf_u00;
  logic [N-1:0] kf_u10;
  logic [N-1:0] kf_z00;
  logic [N-1:0] kf_z10;
  logic [N-1:0] kf_x00_prev;
  logic [N-1:0] kf_x10_prev;
  // Estimate output stream
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_x00;
  logic [N-1:0] m_x10;
  logic         m_timeout;

  // Sequencer side
  modport master (
    input  s_valid, s_u00, s_z00, s_z10,
    input  kf_done, kf_x00_post, kf_x10_post,
    input  m_ready,
    output s_ready,
    output kf_start, kf_u00, kf_u10, kf_z00, kf_z10, kf_x00_prev, kf_x10_prev,
    output m_valid, m_x00, m_x10, m_timeout
  );

  // Environment side (sample source, top_kf, estimate sink)
  modport slave (
    output s_valid, s_u00, s_z00, s_z10,
    output kf_done, kf_x00_post, kf_x10_post,
    output m_ready,
    input  s_ready,
    input  kf_start, kf_u00, kf_u10, kf_z00, kf_z10, kf_x00_prev, kf_x10_prev,
    input  m_valid, m_x00, m_x10, m_timeout
  );
endinterface

`default_nettype wire

// File: rtl/kf_frame_sequencer.sv
//============================================================================
// Module   : kf_frame_sequencer
// Purpose  : Per-frame initiator for top_kf. Accepts one sample, launches a
//            filter frame, waits for completion under a watchdog, feeds the
//            posterior back as the next prior and emits the estimate.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module kf_frame_sequencer #(
  parameter int N       = 20,
  parameter int FRAC    = 10,
  parameter int TIMEOUT = 38,
  parameter int CNT_W   = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear_state_i,
  kf_frame_sequencer_if.master  bus,
  output logic                  timeout_err_o,
  output logic [CNT_W-1:0]      frame_cnt_o
);

  // Words are opaque here; only a sanity check on the fixed-point format.
  if (FRAC < 0 || FRAC >= N) begin : g_bad_frac
    $error("kf_frame_sequencer: FRAC must lie in [0, N)");
  end

  localparam int             C_CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_CW-1:0] C_WAIT_LAST = C_CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  state_t           state_q;
  logic [C_CW-1:0]  cnt_q;
  logic [C_CW-1:0]  cnt_d;
  logic             s_ready_q;
  logic             kf_start_q;
  logic [N-1:0]     u00_q;
  logic [N-1:0]     z00_q;
  logic [N-1:0]     z10_q;
  logic [N-1:0]     x00_prev_q;
  logic [N-1:0]     x10_prev_q;
  logic             m_valid_q;
  logic [N-1:0]     m_x00_q;
  logic [N-1:0]     m_x10_q;
  logic             m_timeout_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] frame_cnt_q;

  // Watchdog counter next value; it only runs while waiting for kf_done.
  always_comb begin
    cnt_d = cnt_q + C_CW'(1);
  end

  // Frame sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      s_ready_q     <= 1'b0;
      kf_start_q    <= 1'b0;
      u00_q         <= '0;
      z00_q         <= '0;
      z10_q         <= '0;
      x00_prev_q    <= '0;
      x10_prev_q    <= '0;
      m_valid_q     <= 1'b0;
      m_x00_q       <= '0;
      m_x10_q       <= '0;
      m_timeout_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Clearing in the accept cycle means the accepted frame starts from zero.
          if (clear_state_i) begin
            x00_prev_q <= '0;
            x10_prev_q <= '0;
          end
          if (bus.s_valid && s_ready_q) begin
            u00_q      <= bus.s_u00;
            z00_q      <= bus.s_z00;
            z10_q      <= bus.s_z10;
            s_ready_q  <= 1'b0;
            kf_start_q <= 1'b1;
            state_q    <= ST_LAUNCH;
          end else begin
            s_ready_q  <= 1'b1;
          end
        end

        ST_LAUNCH: begin
          kf_start_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          cnt_q <= cnt_d;
          // Done wins over a coincident watchdog expiry.
          if (bus.kf_done) begin
            x00_prev_q  <= bus.kf_x00_post;
            x10_prev_q  <= bus.kf_x10_post;
            m_x00_q     <= bus.kf_x00_post;
            m_x10_q     <= bus.kf_x10_post;
            m_timeout_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            m_valid_q   <= 1'b1;
            state_q     <= ST_OUT;
          end else if (cnt_q == C_WAIT_LAST) begin
            // Abandoned frame: report the unchanged prior as the estimate.
            m_x00_q       <= x00_prev_q;
            m_x10_q       <= x10_prev_q;
            m_timeout_q   <= 1'b1;
            timeout_err_q <= 1'b1;
            m_valid_q     <= 1'b1;
            state_q       <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.kf_start    = kf_start_q;
  assign bus.kf_u00      = u00_q;
  assign bus.kf_u10      = '0;
  assign bus.kf_z00      = z00_q;
  assign bus.kf_z10      = z10_q;
  assign bus.kf_x00_prev = x00_prev_q;
  assign bus.kf_x10_prev = x10_prev_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_x00       = m_x00_q;
  assign bus.m_x10       = m_x10_q;
  assign bus.m_timeout   = m_timeout_q;
  assign timeout_err_o   = timeout_err_q;
  assign frame_cnt_o     = frame_cnt_q;

endmodule

`default_nettype wire
